paralle_bus_master: RTL

- Bus master for the 10-bit-address / 8-bit-data parallel slave bus with BWR/BRD strobes.
- Shares one bus between two internal requesters using round-robin arbitration.
- Sequences each access as setup, strobe and hold phases, with programmable cycle counts.
- Drives the slave's configuration registers, e.g. the setup register at address 0x050.

---
 rtl/paralle_bus_master.sv | 119 +++++++++++
 1 files changed

// File: rtl/paralle_bus_master.sv
// Two-requester master for the 10-bit address / 8-bit data BWR/BRD slave bus, with
// setup/strobe/hold phasing. Define PBM_FIXED_PRIORITY_EN for fixed priority (requester 0 wins).
`timescale 1ns/1ps
module paralle_bus_master #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REQ0,
  input  logic       WR0,
  input  logic [9:0] ADR0,
  input  logic [7:0] WDATA0,
  output logic       ACK0,
  input  logic       REQ1,
  input  logic       WR1,
  input  logic [9:0] ADR1,
  input  logic [7:0] WDATA1,
  output logic       ACK1,
  output logic [7:0] RDATA,
  output logic       BUSY,
  output logic [9:0] ADR,
  inout  wire  [7:0] Data,
  output logic       BWR,
  output logic       BRD,
  output logic [1:0] fsm_state,
  output logic       data_drive
);
  // Handshake: REQn is a level sampled only in IDLE; ACKn is a one-cycle pulse in the
  // last HOLD cycle of the granted access. A REQn still high after its ACK is a new request.

  // Zero cycle counts behave like one.
  localparam logic [3:0] SETUP_LD  = (SETUP_CYC  == 0) ? 4'd0 : 4'(SETUP_CYC  - 1);
  localparam logic [3:0] STROBE_LD = (STROBE_CYC == 0) ? 4'd0 : 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = (HOLD_CYC   == 0) ? 4'd0 : 4'(HOLD_CYC   - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       any_req, gnt_sel, last;
  logic       cap_wr, sel_q, data_oe;
  logic [7:0] cap_wdata;
`ifndef PBM_FIXED_PRIORITY_EN
  logic       rr_ptr;
`endif

  assign any_req = REQ0 | REQ1;
`ifdef PBM_FIXED_PRIORITY_EN
  assign gnt_sel = ~REQ0;
`else
  assign gnt_sel = (REQ0 & REQ1) ? rr_ptr : REQ1;
`endif
  assign last = (cnt == 4'd0);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = last ? 4'd0 : cnt - 4'd1;
    case (state)
      IDLE:   if (any_req) begin next_state = SETUP;  next_cnt = SETUP_LD;  end
      SETUP:  if (last)    begin next_state = STROBE; next_cnt = STROBE_LD; end
      STROBE: if (last)    begin next_state = HOLD;   next_cnt = HOLD_LD;   end
      HOLD:   if (last)    begin next_state = IDLE;   next_cnt = 4'd0;      end
      default: begin next_state = IDLE; next_cnt = 4'd0; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cap_wr    <= 1'b0;
      cap_wdata <= 8'h00;
      sel_q     <= 1'b0;
      ADR       <= 10'h000;
      RDATA     <= 8'h00;
      BWR       <= 1'b1;
      BRD       <= 1'b1;
      data_oe   <= 1'b0;
`ifndef PBM_FIXED_PRIORITY_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      if (state == IDLE && any_req) begin
        sel_q     <= gnt_sel;
        cap_wr    <= gnt_sel ? WR1 : WR0;
        ADR       <= gnt_sel ? ADR1 : ADR0;
        cap_wdata <= gnt_sel ? WDATA1 : WDATA0;
        data_oe   <= gnt_sel ? WR1 : WR0;
`ifndef PBM_FIXED_PRIORITY_EN
        rr_ptr    <= ~gnt_sel;
`endif
      end else if (state == HOLD && last) begin
        data_oe <= 1'b0;
      end
      // Sample on the edge that ends the strobe, while the slave is still driving.
      if (state == STROBE && last && !cap_wr) RDATA <= Data;
      BWR <= !(next_state == STROBE && cap_wr);
      BRD <= !(next_state == STROBE && !cap_wr);
    end
  end

  assign Data       = data_oe ? cap_wdata : 8'bz;
  assign ACK0       = (state == HOLD) && last && !sel_q;
  assign ACK1       = (state == HOLD) && last && sel_q;
  assign BUSY       = (state != IDLE);
  assign fsm_state  = state;
  assign data_drive = data_oe;

endmodule
